counter_updown_mod: RTL and testbench

Parametrised up/down modulo counter: the next generation of the team's 12-bit up/down counter, generalised to any width, a programmable modulus and a per-cycle step size. It adds a count enable, clamping on load, and terminal-count and boundary flags. It is a general sequential building block for timers, address generators and rate dividers. Wrap-around versus saturation at the bounds is selected at build time.

---
 rtl/counter_updown_mod.sv | 134 +++++++++++++
 tb/tb_counter_updown_mod.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_updown_mod.sv
// -----------------------------------------------------------------------------
// counter_updown_mod
//
// Parametrised up/down modulo counter with programmable inclusive upper bound
// (MAX_VAL), per-cycle step size, count enable, clamped synchronous load,
// registered terminal-count pulse and combinational boundary flags.
//
// Build-time option:
//   COUNTER_SATURATE_EN  defined   -> a bound crossing clamps to MAX_VAL / 0
//                        undefined -> a bound crossing wraps modulo MAX_VAL+1
//
// Parameters:
//   WIDTH    counter width in bits
//   MAX_VAL  inclusive upper bound, 1 <= MAX_VAL <= 2^WIDTH-1
//   STEP_W   step input width, 2^STEP_W-1 <= MAX_VAL
//
// Ports:
//   clk_in        in   rising-edge clock
//   rst_in        in   asynchronous active-high reset
//   en_in         in   count enable (does not gate load)
//   sync_load_in  in   synchronous load of count_in (clamped to MAX_VAL)
//   count_in      in   load value
//   updown_in     in   direction, 1 = up, 0 = down
//   step_in       in   step amount, 0 = hold
//   count_out     out  registered count, always within 0..MAX_VAL
//   tc_out        out  registered pulse, high the cycle after a bound crossing
//   at_max_out    out  count_out == MAX_VAL
//   at_min_out    out  count_out == 0
// -----------------------------------------------------------------------------
module counter_updown_mod #(
    parameter int WIDTH   = 12,
    parameter int MAX_VAL = 4095,
    parameter int STEP_W  = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              en_in,
    input  logic              sync_load_in,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              updown_in,
    input  logic [STEP_W-1:0] step_in,
    output logic [WIDTH-1:0]  count_out,
    output logic              tc_out,
    output logic              at_max_out,
    output logic              at_min_out
);

    // Bound and modulus carried at WIDTH+1 bits so MAX_VAL+1 == 2^WIDTH fits.
    localparam logic [WIDTH:0]   LP_MAX   = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   LP_MOD   = (WIDTH+1)'(MAX_VAL + 1);
    localparam logic [WIDTH-1:0] LP_MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;

    logic [WIDTH:0]   w_cnt_ext;
    logic [WIDTH:0]   w_step_ext;
    logic [WIDTH:0]   w_load_ext;
    logic [WIDTH:0]   w_sum;
    logic             w_up_cross;
    logic             w_dn_cross;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_up_wrap;
    logic [WIDTH-1:0] w_dn_wrap;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_tc;

    // All arithmetic is one bit wider than the count so nothing truncates
    // before the bound comparisons.
    assign w_cnt_ext  = {1'b0, r_count};
    assign w_step_ext = {{(WIDTH+1-STEP_W){1'b0}}, step_in};
    assign w_load_ext = {1'b0, count_in};

    assign w_sum      = w_cnt_ext + w_step_ext;
    assign w_up_cross = (w_sum > LP_MAX);
    assign w_dn_cross = (w_step_ext > w_cnt_ext);

    // Each result below is only selected when it is known to be < MAX_VAL+1,
    // so dropping the top bit is lossless.
    assign w_diff     = WIDTH'(w_cnt_ext - w_step_ext);
    assign w_up_wrap  = WIDTH'(w_sum - LP_MOD);
    assign w_dn_wrap  = WIDTH'(w_cnt_ext + LP_MOD - w_step_ext);

    assign w_load_val = (w_load_ext > LP_MAX) ? LP_MAX_W : count_in;

    always_comb begin
        w_next_count = r_count;
        w_next_tc    = 1'b0;
        if (sync_load_in) begin
            w_next_count = w_load_val;
        end else if (en_in && (step_in != '0)) begin
            if (updown_in) begin
                if (w_up_cross) begin
                    w_next_tc = 1'b1;
`ifdef COUNTER_SATURATE_EN
                    w_next_count = LP_MAX_W;
`else
                    w_next_count = w_up_wrap;
`endif
                end else begin
                    w_next_count = w_sum[WIDTH-1:0];
                end
            end else begin
                if (w_dn_cross) begin
                    w_next_tc = 1'b1;
`ifdef COUNTER_SATURATE_EN
                    w_next_count = '0;
`else
                    w_next_count = w_dn_wrap;
`endif
                end else begin
                    w_next_count = w_diff;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_tc    <= w_next_tc;
        end
    end

    assign count_out  = r_count;
    assign tc_out     = r_tc;
    assign at_max_out = (r_count == LP_MAX_W);
    assign at_min_out = (r_count == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
module tb_counter_updown_mod;

    localparam int WIDTH  = 12;
    localparam int MAXV   = 999;
    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              load;
    logic [WIDTH-1:0]  cin;
    logic              up;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  count_out;
    logic              tc_out;
    logic              at_max_out;
    logic              at_min_out;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    int m_count = 0;
    int m_tc    = 0;

    counter_updown_mod #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAXV),
        .STEP_W  (STEP_W)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .en_in        (en),
        .sync_load_in (load),
        .count_in     (cin),
        .updown_in    (up),
        .step_in      (step),
        .count_out    (count_out),
        .tc_out       (tc_out),
        .at_max_out   (at_max_out),
        .at_min_out   (at_min_out)
    );

    always #5 clk = ~clk;

    // Reference behaviour in plain integer arithmetic.
    function automatic int raw_next(int c, bit ld, int ci, bit e, bit u, int s);
        if (ld) return (ci > MAXV) ? MAXV : ci;
        if (!e || s == 0) return c;
        return u ? c + s : c - s;
    endfunction

    function automatic int model_count(int c, bit ld, int ci, bit e, bit u, int s);
        int r;
        r = raw_next(c, ld, ci, e, u, s);
        if (r >= 0 && r <= MAXV) return r;
`ifdef COUNTER_SATURATE_EN
        return (r < 0) ? 0 : MAXV;
`else
        return ((r % (MAXV + 1)) + (MAXV + 1)) % (MAXV + 1);
`endif
    endfunction

    function automatic int model_tc(int c, bit ld, int ci, bit e, bit u, int s);
        int r;
        r = raw_next(c, ld, ci, e, u, s);
        return (!ld && (r < 0 || r > MAXV)) ? 1 : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_count <= 0;
            m_tc    <= 0;
        end else begin
            m_count <= model_count(m_count, load, int'(cin), en, up, int'(step));
            m_tc    <= model_tc(m_count, load, int'(cin), en, up, int'(step));
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_count", int'(count_out), m_count);
            check("model_tc", int'(tc_out), m_tc);
            check("model_at_max", int'(at_max_out), (m_count == MAXV) ? 1 : 0);
            check("model_at_min", int'(at_min_out), (m_count == 0) ? 1 : 0);
        end
    end

    // Drive one vector (we are 2 time units past an edge), let it be sampled
    // on the next rising edge, and return 2 time units after that edge.
    task automatic cyc(input bit ld, input int ci, input bit e, input bit u, input int s);
        load = ld;
        cin  = WIDTH'(ci);
        en   = e;
        up   = u;
        step = STEP_W'(s);
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string name, input int c, input int tc);
        check({name, "_count"}, int'(count_out), c);
        check({name, "_tc"}, int'(tc_out), tc);
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b1;
        cin  = 12'd1024;
        en   = 1'b0;
        up   = 1'b1;
        step = '0;
        #1;
        check("reset_count", int'(count_out), 0);
        check("reset_tc", int'(tc_out), 0);
        check("reset_at_min", int'(at_min_out), 1);
        check("reset_at_max", int'(at_max_out), 0);
        @(posedge clk);
        #2;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Load then count.
        cyc(1, 500, 0, 1, 0);  expect_out("load500", 500, 0);
        cyc(0, 0, 1, 1, 1);    expect_out("up1_a", 501, 0);
        cyc(0, 0, 1, 1, 1);    expect_out("up1_b", 502, 0);
        cyc(0, 0, 1, 1, 1);    expect_out("up1_c", 503, 0);
        cyc(0, 0, 1, 0, 1);    expect_out("down1", 502, 0);

        // Asynchronous reset mid-count.
        cyc(1, 503, 0, 1, 0);  expect_out("load503", 503, 0);
        #1 rst = 1'b1;
        #1 check("async_rst_count", int'(count_out), 0);
        check("async_rst_at_min", int'(at_min_out), 1);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Up crossing.
        cyc(1, 998, 0, 1, 0);  expect_out("load998", 998, 0);
        cyc(0, 0, 1, 1, 3);
`ifdef COUNTER_SATURATE_EN
        expect_out("up_cross", 999, 1);
        cyc(0, 0, 1, 1, 3);    expect_out("up_cross_again", 999, 1);
        cyc(0, 0, 0, 1, 3);    expect_out("after_cross", 999, 0);
`else
        expect_out("up_cross", 1, 1);
        cyc(0, 0, 0, 1, 3);    expect_out("after_cross", 1, 0);
`endif

        // Down crossing.
        cyc(1, 2, 0, 0, 0);    expect_out("load2", 2, 0);
        cyc(0, 0, 1, 0, 5);
`ifdef COUNTER_SATURATE_EN
        expect_out("down_cross", 0, 1);
        check("down_cross_at_min", int'(at_min_out), 1);
`else
        expect_out("down_cross", 997, 1);
`endif

        // Load clamp and exact landing on the bound.
        cyc(1, 4000, 0, 1, 0); expect_out("load_clamp", 999, 0);
        check("load_clamp_at_max", int'(at_max_out), 1);
        cyc(1, 996, 0, 1, 0);  expect_out("load996", 996, 0);
        cyc(0, 0, 1, 1, 3);    expect_out("land_max", 999, 0);
        check("land_max_at_max", int'(at_max_out), 1);

        // Holds, and load with enable low.
        cyc(0, 0, 0, 1, 5);    expect_out("hold_en0", 999, 0);
        cyc(0, 0, 1, 1, 0);    expect_out("hold_step0", 999, 0);
        cyc(1, 123, 0, 0, 7);  expect_out("load_en0", 123, 0);

        // Landing exactly on zero, then back-to-back crossings.
        cyc(1, 5, 0, 0, 0);    expect_out("load5", 5, 0);
        cyc(0, 0, 1, 0, 5);    expect_out("land_min", 0, 0);
        cyc(0, 0, 1, 0, 1);
`ifdef COUNTER_SATURATE_EN
        expect_out("b2b_1", 0, 1);
        cyc(0, 0, 1, 0, 15);   expect_out("b2b_2", 0, 1);
`else
        expect_out("b2b_1", 999, 1);
        cyc(0, 0, 1, 1, 15);   expect_out("b2b_2", 14, 1);
`endif
        cyc(1, 7, 1, 1, 15);   expect_out("load_over_count", 7, 0);

        // Mixed sweep, checked against the model every cycle.
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 7) == 0), int'($urandom_range(0, 4095)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 15)));
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
